// File: rtl/max7219_pkg.sv
// rtl/max7219_pkg.sv - MAX7219 register map, init-frame table and driver FSM states
package max7219_pkg;

    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCAN      = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    // Frame indices 0..4 are the init table, 5..10 the six digit frames
    localparam logic [3:0] FIRST_DIGIT_FRAME = 4'd5;
    localparam logic [3:0] LAST_FRAME        = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_FRAME,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH
    } state_t;

    function automatic logic [15:0] init_frame(input logic [3:0] idx, input logic [3:0] intensity);
        case (idx)
            4'd0:    init_frame = {4'h0, ADDR_SHUTDOWN, 8'h01};
            4'd1:    init_frame = {4'h0, ADDR_TEST, 8'h00};
            4'd2:    init_frame = {4'h0, ADDR_DECODE, 8'h00};
            4'd3:    init_frame = {4'h0, ADDR_INTENSITY, 4'h0, intensity};
            default: init_frame = {4'h0, ADDR_SCAN, 8'h05};
        endcase
    endfunction

endpackage

// File: rtl/max7219_display_driver_bcd_to_seg7.sv
// rtl/max7219_display_driver_bcd_to_seg7.sv - BCD digit to raw segment code {DP,A..G}, blank above 9
module bcd_to_seg7 (
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = 8'h00;
        case (bcd)
            4'd0: seg = 8'h7E;
            4'd1: seg = 8'h30;
            4'd2: seg = 8'h6D;
            4'd3: seg = 8'h79;
            4'd4: seg = 8'h33;
            4'd5: seg = 8'h5B;
            4'd6: seg = 8'h5F;
            4'd7: seg = 8'h70;
            4'd8: seg = 8'h7F;
            4'd9: seg = 8'h7B;
            default: seg = 8'h00;
        endcase
    end

endmodule

// File: rtl/max7219_display_driver.sv
// rtl/max7219_display_driver.sv - serialises HH:MM:SS BCD digits into MAX7219 frames on DIN/CLK/LOAD
module max7219_display_driver
    import max7219_pkg::*;
#(
    parameter int         SCLK_DIV  = 2,
    parameter logic [3:0] INTENSITY = 4'h8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic        i_update_stb,
    input  logic [23:0] i_bcd_digits,
    output logic        o_serial_dout,
    output logic        o_serial_clk,
    output logic        o_serial_load,
    output logic        o_busy
);

    localparam int DW = (2 * SCLK_DIV > 1) ? $clog2(2 * SCLK_DIV) : 1;
    localparam logic [DW-1:0] HALF_END  = DW'(SCLK_DIV - 1);
    localparam logic [DW-1:0] LATCH_END = DW'(2 * SCLK_DIV - 1);

    state_t        state;
    state_t        next_state;
    logic [DW-1:0] div_cnt;
    logic [3:0]    bit_cnt;
    logic [3:0]    frame_idx;
    logic [23:0]   snap;
    logic          init_done;
    logic          pending;
    logic [3:0]    digit_bcd;
    logic [7:0]    seg;
    logic [15:0]   word;
    logic          start;
    logic          half_done;
    logic          latch_done;
    logic          dout_d;
    logic          clk_d;
    logic          load_d;
    logic          busy_d;

    bcd_to_seg7 u_seg (
        .bcd (digit_bcd),
        .seg (seg)
    );

    always_comb begin
        digit_bcd = 4'h0;
        case (frame_idx)
            4'd5:    digit_bcd = snap[23:20];
            4'd6:    digit_bcd = snap[19:16];
            4'd7:    digit_bcd = snap[15:12];
            4'd8:    digit_bcd = snap[11:8];
            4'd9:    digit_bcd = snap[7:4];
            4'd10:   digit_bcd = snap[3:0];
            default: digit_bcd = 4'h0;
        endcase
    end

    // Digit frame n (index 5..10) targets register ADDR_DIGIT0 + n - 5
    always_comb begin
        if (frame_idx < FIRST_DIGIT_FRAME)
            word = init_frame(frame_idx, INTENSITY);
        else
            word = {4'h0, frame_idx - FIRST_DIGIT_FRAME + ADDR_DIGIT0, seg};
    end

    assign start      = !init_done || (i_en && (pending || i_update_stb));
    assign half_done  = (div_cnt == HALF_END);
    assign latch_done = (div_cnt == LATCH_END);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:       if (start) next_state = S_LOAD_FRAME;
            S_LOAD_FRAME: next_state = S_SHIFT_LO;
            S_SHIFT_LO:   if (half_done) next_state = S_SHIFT_HI;
            S_SHIFT_HI: begin
                if (half_done)
                    next_state = (bit_cnt == 4'd0) ? S_LATCH : S_SHIFT_LO;
            end
            S_LATCH: begin
                if (latch_done)
                    next_state = (frame_idx == LAST_FRAME) ? S_IDLE : S_LOAD_FRAME;
            end
            default:      next_state = S_IDLE;
        endcase
    end

    // Pad values are computed for the state being entered so the registers line up with it
    always_comb begin
        clk_d  = (next_state == S_SHIFT_HI);
        load_d = (next_state == S_LATCH);
        busy_d = (next_state != S_IDLE);
        dout_d = o_serial_dout;
        if (state == S_LOAD_FRAME)
            dout_d = word[4'd15];
        else if (state == S_SHIFT_HI && next_state == S_SHIFT_LO)
            dout_d = word[bit_cnt - 4'd1];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            div_cnt   <= '0;
            bit_cnt   <= 4'd0;
            frame_idx <= 4'd0;
            snap      <= 24'h0;
            init_done <= 1'b0;
            pending   <= 1'b0;
        end else begin
            div_cnt <= (next_state != state) ? '0 : div_cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    if (next_state == S_LOAD_FRAME) begin
                        frame_idx <= init_done ? FIRST_DIGIT_FRAME : 4'd0;
                        snap      <= i_bcd_digits;
                        init_done <= 1'b1;
                    end
                end
                S_LOAD_FRAME: bit_cnt <= 4'd15;
                S_SHIFT_HI:   if (half_done) bit_cnt <= bit_cnt - 4'd1;
                S_LATCH:      if (next_state == S_LOAD_FRAME) frame_idx <= frame_idx + 4'd1;
                default: ;
            endcase
            if (state == S_IDLE && next_state == S_LOAD_FRAME)
                pending <= 1'b0;
            else if (i_update_stb && i_en && state != S_IDLE)
                pending <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_serial_dout <= 1'b0;
            o_serial_clk  <= 1'b0;
            o_serial_load <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_serial_dout <= dout_d;
            o_serial_clk  <= clk_d;
            o_serial_load <= load_d;
            o_busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_max7219_display_driver.sv
// tb/tb_max7219_display_driver.sv - directed bench with a MAX7219 mock and segment decoder
module tb_max7219_display_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic        stb = 1'b0;
    logic [23:0] digits = 24'h123456;
    logic        dout, sclk, load, busy;

    logic        rst1 = 1'b1;
    logic        stb1 = 1'b0;
    logic        dout1, sclk1, load1, busy1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    max7219_display_driver dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_en          (en),
        .i_update_stb  (stb),
        .i_bcd_digits  (digits),
        .o_serial_dout (dout),
        .o_serial_clk  (sclk),
        .o_serial_load (load),
        .o_busy        (busy)
    );

    max7219_display_driver #(.SCLK_DIV(1), .INTENSITY(4'h3)) dut1 (
        .i_clk         (clk),
        .i_reset       (rst1),
        .i_en          (1'b1),
        .i_update_stb  (stb1),
        .i_bcd_digits  (digits),
        .o_serial_dout (dout1),
        .o_serial_clk  (sclk1),
        .o_serial_load (load1),
        .o_busy        (busy1)
    );

    // MAX7219 mock: shift on CLK rise, latch on LOAD rise
    logic [15:0] sh = 16'h0;
    logic [15:0] frames [0:255];
    int          nframes = 0;
    logic [7:0]  disp [1:6];
    int          nload1 = 0;
    int          viol = 0;
    logic        prev_sclk = 1'b0, prev_dout = 1'b0, prev_sclk1 = 1'b0, prev_dout1 = 1'b0;
    logic [15:0] init_exp [0:4] = '{16'h0C01, 16'h0F00, 16'h0900, 16'h0A08, 16'h0B05};

    always @(posedge sclk) sh <= {sh[14:0], dout};

    always @(posedge load) begin
        if (nframes < 256) frames[nframes] = sh;
        nframes++;
        if (sh[11:8] >= 4'd1 && sh[11:8] <= 4'd6) disp[sh[11:8]] = sh[7:0];
    end

    always @(posedge load1) nload1++;

    always @(negedge clk) begin
        if (sclk && !prev_sclk && dout !== prev_dout) viol++;
        if (sclk1 && !prev_sclk1 && dout1 !== prev_dout1) viol++;
        prev_sclk  = sclk;
        prev_dout  = dout;
        prev_sclk1 = sclk1;
        prev_dout1 = dout1;
    end

    function automatic logic [3:0] seg2bcd(input logic [7:0] s);
        case (s)
            8'h7E: seg2bcd = 4'd0;
            8'h30: seg2bcd = 4'd1;
            8'h6D: seg2bcd = 4'd2;
            8'h79: seg2bcd = 4'd3;
            8'h33: seg2bcd = 4'd4;
            8'h5B: seg2bcd = 4'd5;
            8'h5F: seg2bcd = 4'd6;
            8'h70: seg2bcd = 4'd7;
            8'h7F: seg2bcd = 4'd8;
            8'h7B: seg2bcd = 4'd9;
            8'h00: seg2bcd = 4'hF;
            default: seg2bcd = 4'hE;
        endcase
    endfunction

    // Counts busy-high cycles and idle cycles between bursts; raises stb on chosen busy cycles
    task automatic measure(input int s0, input int s1, input int s2, input int chg_at,
                           input logic [23:0] chg_val, output int hi, output int gap, output bit done);
        int run;
        hi = 0; gap = 0; run = 0; done = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (busy) begin
                hi++;
                gap += run;
                run = 0;
            end else if (hi > 0) begin
                run++;
                if (run >= 8) begin
                    done = 1'b1;
                    break;
                end
            end
            stb = busy && (hi == s0 || hi == s1 || hi == s2);
            if (busy && hi == chg_at) digits = chg_val;
        end
        stb = 1'b0;
    endtask

    task automatic measure1(output int hi, output bit done);
        hi = 0; done = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (busy1) hi++;
            else if (hi > 0) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    task automatic strobe;
        @(negedge clk);
        stb = 1'b1;
    endtask

    task automatic test_reset;
        int hi, gap, n0;
        bit done;
        rst = 1'b1;
        digits = 24'h123456;
        repeat (3) @(negedge clk);
        tests++; if ({dout, sclk, load, busy} !== 4'b0000) begin fails++; $display("FAIL reset_outputs: got %b expected 0000", {dout, sclk, load, busy}); end
        n0 = nframes;
        rst = 1'b0;
        measure(-1, -1, -1, -1, 24'h0, hi, gap, done);
        tests++; if (!done) begin fails++; $display("FAIL init_timeout: burst did not end"); end
        tests++; if (hi !== 759) begin fails++; $display("FAIL init_busy_cycles: got %0d expected 759", hi); end
        tests++; if (nframes - n0 !== 11) begin fails++; $display("FAIL init_load_edges: got %0d expected 11", nframes - n0); end
        for (int i = 0; i < 5; i++) begin
            tests++; if (frames[n0 + i] !== init_exp[i]) begin fails++; $display("FAIL init_frame_%0d: got %h expected %h", i, frames[n0 + i], init_exp[i]); end
        end
        for (int i = 1; i <= 6; i++) begin
            tests++; if (seg2bcd(disp[i]) !== 4'(i)) begin fails++; $display("FAIL init_digit_%0d: got %h expected %0d", i, seg2bcd(disp[i]), i); end
        end
    endtask

    task automatic test_update;
        int hi, gap, n0;
        bit done;
        logic [3:0] exp [1:6] = '{4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9};
        digits = 24'h235959;
        n0 = nframes;
        strobe();
        measure(-1, -1, -1, -1, 24'h0, hi, gap, done);
        tests++; if (!done || hi !== 414) begin fails++; $display("FAIL update_busy_cycles: got %0d expected 414", hi); end
        tests++; if (nframes - n0 !== 6) begin fails++; $display("FAIL update_load_edges: got %0d expected 6", nframes - n0); end
        tests++; if (frames[n0] !== 16'h016D) begin fails++; $display("FAIL update_first_frame: got %h expected 016d", frames[n0]); end
        for (int i = 1; i <= 6; i++) begin
            tests++; if (seg2bcd(disp[i]) !== exp[i]) begin fails++; $display("FAIL update_digit_%0d: got %h expected %h", i, seg2bcd(disp[i]), exp[i]); end
        end
    endtask

    task automatic test_back_to_back;
        int hi, gap, n0;
        bit done;
        digits = 24'h000000;
        n0 = nframes;
        strobe();
        measure(50, 100, 200, 60, 24'h111111, hi, gap, done);
        tests++; if (!done || hi !== 828) begin fails++; $display("FAIL b2b_busy_cycles: got %0d expected 828", hi); end
        tests++; if (gap !== 1) begin fails++; $display("FAIL b2b_idle_gap: got %0d expected 1", gap); end
        tests++; if (nframes - n0 !== 12) begin fails++; $display("FAIL b2b_load_edges: got %0d expected 12", nframes - n0); end
        tests++; if (frames[n0 + 5] !== 16'h067E) begin fails++; $display("FAIL b2b_snapshot: got %h expected 067e", frames[n0 + 5]); end
        for (int i = 1; i <= 6; i++) begin
            tests++; if (disp[i] !== 8'h30) begin fails++; $display("FAIL b2b_digit_%0d: got %h expected 30", i, disp[i]); end
        end
    endtask

    task automatic test_latch_edge;
        int hi, gap, n0;
        bit done;
        digits = 24'h010203;
        n0 = nframes;
        strobe();
        measure(414, -1, -1, -1, 24'h0, hi, gap, done);
        tests++; if (!done || hi !== 828 || gap !== 1) begin fails++; $display("FAIL latch_edge_pending: got hi=%0d gap=%0d expected 828/1", hi, gap); end
        tests++; if (nframes - n0 !== 12) begin fails++; $display("FAIL latch_edge_loads: got %0d expected 12", nframes - n0); end
    endtask

    task automatic test_blank;
        int hi, gap;
        bit done;
        logic [7:0] exp [1:6] = '{8'h7E, 8'h7E, 8'h00, 8'h00, 8'h7E, 8'h7E};
        digits = 24'h00FA00;
        strobe();
        measure(-1, -1, -1, -1, 24'h0, hi, gap, done);
        tests++; if (!done || hi !== 414) begin fails++; $display("FAIL blank_busy_cycles: got %0d expected 414", hi); end
        for (int i = 1; i <= 6; i++) begin
            tests++; if (disp[i] !== exp[i]) begin fails++; $display("FAIL blank_seg_%0d: got %h expected %h", i, disp[i], exp[i]); end
        end
    endtask

    task automatic test_reset_mid;
        int hi, gap, n0, n1;
        bit done;
        digits = 24'h777777;
        n0 = nframes;
        strobe();
        hi = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            stb = 1'b0;
            if (busy) hi++;
            if (hi == 172) break;
        end
        tests++; if (hi !== 172) begin fails++; $display("FAIL midreset_reach: got %0d expected 172", hi); end
        rst = 1'b1;
        #1;
        tests++; if ({dout, sclk, load, busy} !== 4'b0000) begin fails++; $display("FAIL midreset_outputs: got %b expected 0000", {dout, sclk, load, busy}); end
        repeat (5) @(negedge clk);
        tests++; if (nframes - n0 !== 2) begin fails++; $display("FAIL midreset_no_latch: got %0d expected 2", nframes - n0); end
        n1 = nframes;
        rst = 1'b0;
        measure(-1, -1, -1, -1, 24'h0, hi, gap, done);
        tests++; if (!done || hi !== 759 || nframes - n1 !== 11) begin fails++; $display("FAIL midreset_reinit: got hi=%0d loads=%0d expected 759/11", hi, nframes - n1); end
        tests++; if (frames[n1] !== 16'h0C01) begin fails++; $display("FAIL midreset_first_frame: got %h expected 0c01", frames[n1]); end
    endtask

    task automatic test_disabled;
        int hi, n0;
        n0 = nframes;
        en = 1'b0;
        strobe();
        @(negedge clk);
        stb = 1'b0;
        hi = 0;
        repeat (100) begin @(negedge clk); if (busy) hi++; end
        en = 1'b1;
        repeat (20) begin @(negedge clk); if (busy) hi++; end
        tests++; if (hi !== 0 || nframes !== n0) begin fails++; $display("FAIL disabled_activity: got busy=%0d loads=%0d expected 0/0", hi, nframes - n0); end
    endtask

    task automatic test_sclk1;
        int hi;
        bit done;
        @(negedge clk);
        rst1 = 1'b0;
        measure1(hi, done);
        tests++; if (!done || hi !== 385) begin fails++; $display("FAIL sclk1_init_cycles: got %0d expected 385", hi); end
        tests++; if (nload1 !== 11) begin fails++; $display("FAIL sclk1_init_loads: got %0d expected 11", nload1); end
        @(negedge clk);
        stb1 = 1'b1;
        @(negedge clk);
        stb1 = 1'b0;
        measure1(hi, done);
        tests++; if (!done || hi !== 209) begin fails++; $display("FAIL sclk1_frame_len: got %0d expected 209 after first cycle", hi); end
        tests++; if (nload1 !== 17) begin fails++; $display("FAIL sclk1_update_loads: got %0d expected 17", nload1); end
        tests++; if (viol !== 0) begin fails++; $display("FAIL din_stable: got %0d changes at clk rise expected 0", viol); end
    endtask

    initial begin
        test_reset();
        test_update();
        test_back_to_back();
        test_latch_edge();
        test_blank();
        test_reset_mid();
        test_disabled();
        test_sclk1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
